// File: rtl/spi_load_pkg.sv
// Shared command codes, widths and FSM state encoding for the SPI load bridge.
package spi_load_pkg;

   localparam int CMD_W = 8;

   localparam logic [CMD_W-1:0] CMD_WRITE  = 8'h01;
   localparam logic [CMD_W-1:0] CMD_READ   = 8'h02;
   localparam logic [CMD_W-1:0] CMD_OE_ON  = 8'h03;
   localparam logic [CMD_W-1:0] CMD_OE_OFF = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_SINK  = 3'd4
   } state_t;

endpackage

// File: rtl/spi_load_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin into the clk_i domain.
module spi_load_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) r_sync <= {STAGES{RST_VAL}};
      else        r_sync <= (r_sync << 1) | STAGES'(i_d);
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_load_bridge.sv
// SPI mode-0 slave that loads / reads back a downstream counter and drives its OE.
// Define SPI_LOAD_BRIDGE_READBACK_EN to build the 0x02 READ path.
module spi_load_bridge
   import spi_load_pkg::*;
#(
   parameter int DATA_W      = 52,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              spi_sck,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [DATA_W-1:0] load_data,
   output logic              load_we_n,
   output logic              load_oe_n,
   input  logic [DATA_W-1:0] count_in
);

   localparam int CNT_W = $clog2((DATA_W > CMD_W) ? DATA_W : CMD_W);

   logic w_sck, w_cs_n, w_mosi;
   logic r_sck_d, r_cs_d;

   spi_load_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk_i(clk_i), .rst_n(rst_n), .i_d(spi_sck),  .o_q(w_sck));
   spi_load_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk_i(clk_i), .rst_n(rst_n), .i_d(spi_cs_n), .o_q(w_cs_n));
   spi_load_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk_i), .rst_n(rst_n), .i_d(spi_mosi), .o_q(w_mosi));

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_sck_d <= 1'b0;
         r_cs_d  <= 1'b1;
      end else begin
         r_sck_d <= w_sck;
         r_cs_d  <= w_cs_n;
      end
   end

   // A frame end discards any sck edge seen in the same cycle.
   logic w_cs_fall, w_cs_rise, w_sck_rise, w_sck_fall;
   assign w_cs_fall  = ~w_cs_n & r_cs_d;
   assign w_cs_rise  = w_cs_n & ~r_cs_d;
   assign w_sck_rise = w_sck & ~r_sck_d & ~w_cs_rise;
   assign w_sck_fall = ~w_sck & r_sck_d & ~w_cs_rise;

   state_t                  r_state, w_state_nxt;
   logic [CNT_W-1:0]        r_bit_cnt;
   logic [CMD_W-2:0]        r_cmd;
   // The final write bit goes straight to load_data, so the shadow holds DATA_W-1 bits.
   logic [DATA_W-2:0]       r_shadow;
   logic                    r_we_n, r_oe_n;
   logic [CMD_W-1:0]        w_cmd;
   logic [DATA_W-1:0]       w_shadow_nxt;
   logic                    w_cmd_done, w_wr_last, w_rd_last;

   assign w_cmd        = {r_cmd, w_mosi};
   assign w_shadow_nxt = {r_shadow, w_mosi};
   assign w_cmd_done   = (r_state == ST_CMD)   & w_sck_rise & (r_bit_cnt == CNT_W'(CMD_W-1));
   assign w_wr_last    = (r_state == ST_WDATA) & w_sck_rise & (r_bit_cnt == CNT_W'(DATA_W-1));
   assign w_rd_last    = (r_state == ST_RDATA) & w_sck_rise & (r_bit_cnt == CNT_W'(DATA_W-1));

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_cs_rise) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_CMD;
            ST_CMD: begin
               if (w_cmd_done) begin
                  case (w_cmd)
                     CMD_WRITE: w_state_nxt = ST_WDATA;
`ifdef SPI_LOAD_BRIDGE_READBACK_EN
                     CMD_READ:  w_state_nxt = ST_RDATA;
`endif
                     default:   w_state_nxt = ST_SINK;
                  endcase
               end
            end
            ST_WDATA: if (w_wr_last) w_state_nxt = ST_SINK;
            ST_RDATA: if (w_rd_last) w_state_nxt = ST_SINK;
            default:  w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
         r_cmd     <= '0;
         r_shadow  <= '0;
         load_data <= '0;
         r_we_n    <= 1'b1;
         r_oe_n    <= 1'b1;
      end else begin
         r_we_n <= 1'b1;
         if (r_state == ST_IDLE) begin
            r_bit_cnt <= '0;
         end else if (w_sck_rise) begin
            case (r_state)
               ST_CMD: begin
                  r_cmd     <= w_cmd[CMD_W-2:0];
                  r_bit_cnt <= w_cmd_done ? '0 : r_bit_cnt + 1'b1;
                  if (w_cmd_done && w_cmd == CMD_OE_ON)  r_oe_n <= 1'b0;
                  if (w_cmd_done && w_cmd == CMD_OE_OFF) r_oe_n <= 1'b1;
               end
               ST_WDATA: begin
                  r_shadow  <= w_shadow_nxt[DATA_W-2:0];
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (w_wr_last) begin
                     load_data <= w_shadow_nxt;
                     r_we_n    <= 1'b0;
                  end
               end
               ST_RDATA: r_bit_cnt <= r_bit_cnt + 1'b1;
               default:  r_bit_cnt <= r_bit_cnt;
            endcase
         end
      end
   end

   assign load_we_n = r_we_n;
   assign load_oe_n = r_oe_n;

`ifdef SPI_LOAD_BRIDGE_READBACK_EN
   logic [DATA_W-1:0] r_snap;

   // The fall closing the command byte must not shift: the MSB is still unread.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)
         r_snap <= '0;
      else if (w_cmd_done && w_cmd == CMD_READ)
         r_snap <= count_in;
      else if (r_state == ST_RDATA && w_sck_fall && r_bit_cnt != '0)
         r_snap <= r_snap << 1;
   end

   assign spi_miso = (r_state == ST_RDATA) & r_snap[DATA_W-1];
`else
   logic w_unused_count;
   assign w_unused_count = ^count_in;
   assign spi_miso       = 1'b0;
`endif

endmodule
